rr_arb_sel: RTL
===============

RR_ARB_SEL -- requirements
Module: rr_arb_sel

Interface
REQ-001 SHALL have parameter P_NUM_REQ, default 4, giving the number of requesters (2..16).
REQ-002 SHALL have parameter P_MAX_HOLD, default 8, giving the maximum consecutive grant cycles per requester (>=1).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_req, input, P_NUM_REQ bits: request vector, bit n = requester n.
REQ-006 SHALL have port o_gnt, output, P_NUM_REQ bits: registered one-hot grant (all-zero when idle).
REQ-007 SHALL have port o_sel, output, $clog2(P_NUM_REQ) bits: registered binary index of the granted requester, driving the downstream mux select.
REQ-008 SHALL have port o_valid, output, 1 bit: registered; high exactly when o_gnt is non-zero.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-010 SHALL keep a priority pointer PTR; the winner is the first set bit of i_req scanning PTR, PTR+1, ... modulo P_NUM_REQ.
REQ-011 IDLE: if i_req non-zero at edge k, SHALL enter GRANT with o_gnt/o_sel/o_valid valid after edge k (1-cycle latency); otherwise stay IDLE.
REQ-012 On each new grant to index w, SHALL set PTR = (w+1) mod P_NUM_REQ and clear the hold counter HCNT to 1.
REQ-013 GRANT: while i_req[w] is high and HCNT < P_MAX_HOLD, SHALL hold o_gnt/o_sel unchanged and increment HCNT.
REQ-014 GRANT release: when i_req[w] is low, or HCNT == P_MAX_HOLD, SHALL re-arbitrate in the same edge. If any request is pending, it grants the next winner from PTR with no idle bubble. Otherwise it goes to IDLE.
REQ-015 A requester released by timeout and still requesting SHALL be regranted only if no other requester is pending, because it is last in rotation.
REQ-016 Requests arriving or dropping for non-granted indices during GRANT SHALL not affect the current grant.
REQ-017 In IDLE, o_sel SHALL retain the last granted index so the downstream mux output stays stable; o_gnt = 0, o_valid = 0.
REQ-018 HCNT width SHALL be $clog2(P_MAX_HOLD+1) and SHALL never wrap.
REQ-019 o_gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-020 With i_rst high at an edge, the block SHALL enter IDLE after that edge with o_gnt = 0, o_sel = 0, o_valid = 0, PTR = 0 and HCNT = 0.
REQ-021 Reset during GRANT SHALL drop the grant at that edge; i_req SHALL be ignored on the reset edge.
REQ-022 After reset, requester 0 SHALL have highest priority.

Structure
REQ-023 FSM state encodings (IDLE=1'b0, GRANT=1'b1) SHALL live in the shared include file rr_arb_defs.vh.
REQ-024 The rotating-priority search SHALL be a combinational sub-module rr_pick (inputs: request vector and pointer; outputs: winner index and found flag).
REQ-025 All outputs SHALL be driven from flops; there SHALL be no combinational path from i_req to the outputs.

Verification
REQ-026 Reset, then i_req=4'b0000 for 5 cycles -> o_valid=0, o_gnt=0, o_sel=0 throughout.
REQ-027 i_req=4'b1010 held continuously, P_MAX_HOLD=8 -> grant to index 1 for 8 cycles, then index 3 for 8 cycles, then index 1, with no idle cycle between grants.
REQ-028 Grant on index 0; i_req[0] drops after 3 cycles while i_req=4'b0100 -> next edge o_gnt=4'b0100, o_sel=2.
REQ-029 Only i_req[2] high for 20 cycles, P_MAX_HOLD=8 -> index 2 regranted after each timeout, o_valid stays 1, o_sel stays 2.
REQ-030 i_rst asserted mid-GRANT on index 3 -> next edge o_gnt=0, o_valid=0, o_sel=0; with i_req=4'b1111 after reset, first grant is index 0.
REQ-031 Random i_req for 1000 cycles -> o_gnt is always one-hot or zero, and o_valid equals |o_gnt.

Source files
------------

// File: rtl/rr_arb_sel_pkg.sv
// Common types for the round-robin arbiter with mux select output.
`include "rr_arb_defs.vh"

package rr_arb_sel_pkg;

    typedef enum logic {
        ST_IDLE  = `RR_ARB_IDLE,
        ST_GRANT = `RR_ARB_GRANT
    } state_t;

endpackage

// File: rtl/rr_arb_defs.vh
// Shared FSM state encodings for the round-robin arbiter.
`ifndef RR_ARB_DEFS_VH
`define RR_ARB_DEFS_VH

`define RR_ARB_IDLE  1'b0
`define RR_ARB_GRANT 1'b1

`endif

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request at ptr, ptr+1, ... modulo P_NUM_REQ.
module rr_pick #(
    parameter int P_NUM_REQ = 4
) (
    input  logic [P_NUM_REQ-1:0]         req,
    input  logic [$clog2(P_NUM_REQ)-1:0] ptr,
    output logic [$clog2(P_NUM_REQ)-1:0] idx,
    output logic                         found
);

    localparam int SW = $clog2(P_NUM_REQ);

    logic [SW-1:0]        cand [P_NUM_REQ];
    logic [P_NUM_REQ-1:0] hit;

    // One extra bit on the sum so ptr+offset cannot overflow before the modulo fold.
    genvar gi;
    generate
        for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_rot
            logic [SW:0] sum;
            assign sum       = {1'b0, ptr} + (SW+1)'(gi);
            assign cand[gi]  = (sum >= (SW+1)'(P_NUM_REQ)) ? SW'(sum - (SW+1)'(P_NUM_REQ))
                                                            : SW'(sum);
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Descending scan so the smallest offset from ptr is written last and wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx   = cand[i];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_sel.sv
// Round-robin arbiter with bounded hold time and registered one-hot grant / binary select.
module rr_arb_sel
    import rr_arb_sel_pkg::*;
#(
    parameter int P_NUM_REQ  = 4,
    parameter int P_MAX_HOLD = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_NUM_REQ-1:0]         i_req,
    output logic [P_NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(P_NUM_REQ)-1:0] o_sel,
    output logic                         o_valid
);

    localparam int SW = $clog2(P_NUM_REQ);
    localparam int HW = $clog2(P_MAX_HOLD + 1);

    state_t               state_reg, state_next;
    logic [SW-1:0]        ptr_reg, ptr_next;
    logic [HW-1:0]        hcnt_reg, hcnt_next;
    logic [P_NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [SW-1:0]        sel_reg, sel_next;
    logic                 valid_reg, valid_next;

    logic [SW-1:0] win_idx;
    logic          win_found;
    logic          release_now;
    logic          take_new;

    rr_pick #(
        .P_NUM_REQ(P_NUM_REQ)
    ) u_pick (
        .req  (i_req),
        .ptr  (ptr_reg),
        .idx  (win_idx),
        .found(win_found)
    );

    // The owner gives up the mux when it drops its request or exhausts its hold budget.
    assign release_now = !i_req[sel_reg] || (hcnt_reg == HW'(P_MAX_HOLD));

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        hcnt_next  = hcnt_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        take_new   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    take_new = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!release_now) begin
                    hcnt_next = hcnt_reg + HW'(1);
                end else if (win_found) begin
                    take_new = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    gnt_next   = '0;
                    valid_next = 1'b0;
                    hcnt_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The new winner moves to the back of the rotation, so a timed-out owner
        // is only regranted when nobody else is asking.
        if (take_new) begin
            state_next        = ST_GRANT;
            sel_next          = win_idx;
            gnt_next          = '0;
            gnt_next[win_idx] = 1'b1;
            valid_next        = 1'b1;
            hcnt_next         = HW'(1);
            ptr_next          = (win_idx == SW'(P_NUM_REQ - 1)) ? '0 : win_idx + SW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            hcnt_reg  <= '0;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            hcnt_reg  <= hcnt_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
        end
    end

    assign o_gnt   = gnt_reg;
    assign o_sel   = sel_reg;
    assign o_valid = valid_reg;

endmodule
